// File: rtl/ld_st_exec_unit_if.sv
// Memory and CDB buses of the load/store execution unit.
// The unit is the master of both: it raises requests, the environment answers them.
interface ld_st_exec_unit_if #(
    parameter int TAG_W = 6
);
    logic             mem_req;
    logic             mem_we;
    logic [31:0]      mem_addr;
    logic [3:0]       mem_be;
    logic [31:0]      mem_wdata;
    logic [31:0]      mem_rdata;
    logic             mem_ack;
    logic             cdb_req;
    logic             cdb_grant;
    logic [TAG_W-1:0] cdb_tag_out;
    logic [31:0]      cdb_data_out;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata, mem_ack,
        output cdb_req, cdb_tag_out, cdb_data_out,
        input  cdb_grant
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata, mem_ack,
        input  cdb_req, cdb_tag_out, cdb_data_out,
        output cdb_grant
    );
endinterface

// File: rtl/ld_st_exec_unit.sv
// Load/store execution unit: address generation, one req/ack memory transaction,
// load alignment/extension and CDB broadcast. One instruction in flight at a time.
module ld_st_exec_unit #(
    parameter int TAG_W = 6
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 flush,
    input  logic                 issue_valid,
    input  logic [31:0]          issue_rs1_data,
    input  logic [31:0]          issue_rs2_data,
    input  logic [31:0]          issue_imm,
    input  logic                 issue_is_store,
    input  logic [2:0]           issue_funct3,
    input  logic [TAG_W-1:0]     issue_tag,
    output logic                 o_busy,
    output logic                 o_store_done,
    output logic                 o_misalign,
    output logic [TAG_W-1:0]     o_misalign_tag,
    ld_st_exec_unit_if.master    bus
);

    typedef enum logic [1:0] {IDLE, MEM, CDB, DRAIN} state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    state_t           state_q, state_d;
    logic [31:0]      addr_q;
    logic [3:0]       be_q;
    logic [31:0]      wdata_q;
    logic             is_store_q;
    logic [2:0]       funct3_q;
    logic [TAG_W-1:0] tag_q;
    logic [31:0]      load_q;
    logic             store_done_q;
    logic             misalign_q;
    logic [TAG_W-1:0] misalign_tag_q;

    logic             accept;
    logic             load_done;
    logic             store_done_d;
    logic             misalign_d;
    logic [31:0]      addr_sum;
    logic             misaligned;
    logic [3:0]       be_calc;
    logic [31:0]      wdata_calc;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [31:0]      load_data;

    // Address generation, alignment check and store lane mapping for the issuing entry.
    always_comb begin
        addr_sum   = issue_rs1_data + issue_imm;
        misaligned = 1'b0;
        be_calc    = 4'b1111;
        wdata_calc = issue_rs2_data;
        case (issue_funct3)
            F3_B, F3_BU: begin
                misaligned = 1'b0;
                wdata_calc = {4{issue_rs2_data[7:0]}};
                if (issue_is_store) be_calc = 4'b0001 << addr_sum[1:0];
            end
            F3_H, F3_HU: begin
                misaligned = addr_sum[0];
                wdata_calc = {2{issue_rs2_data[15:0]}};
                if (issue_is_store) be_calc = addr_sum[1] ? 4'b1100 : 4'b0011;
            end
            default: misaligned = (addr_sum[1:0] != 2'b00);
        endcase
    end

    // Lane selection and extension of the returning load data.
    always_comb begin
        ld_byte = bus.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        ld_half = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (funct3_q)
            F3_B:    load_data = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   load_data = {24'h0, ld_byte};
            F3_H:    load_data = {{16{ld_half[15]}}, ld_half};
            F3_HU:   load_data = {16'h0, ld_half};
            default: load_data = bus.mem_rdata;
        endcase
    end

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        accept       = 1'b0;
        load_done    = 1'b0;
        store_done_d = 1'b0;
        misalign_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (issue_valid && !flush) begin
                    accept     = 1'b1;
                    misalign_d = misaligned;
                    state_d    = misaligned ? IDLE : MEM;
                end
            end
            MEM: begin
                // A flush that meets the ack retires the access silently; otherwise drain it.
                if (flush) begin
                    state_d = bus.mem_ack ? IDLE : DRAIN;
                end else if (bus.mem_ack) begin
                    if (is_store_q) begin
                        store_done_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        load_done = 1'b1;
                        state_d   = CDB;
                    end
                end
            end
            CDB: begin
                if (flush || bus.cdb_grant) state_d = IDLE;
            end
            DRAIN: begin
                if (bus.mem_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // NOTE: the datapath registers are reset too, because every output must read 0 during reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            addr_q         <= '0;
            be_q           <= '0;
            wdata_q        <= '0;
            is_store_q     <= 1'b0;
            funct3_q       <= '0;
            tag_q          <= '0;
            load_q         <= '0;
            store_done_q   <= 1'b0;
            misalign_q     <= 1'b0;
            misalign_tag_q <= '0;
        end else begin
            store_done_q <= store_done_d;
            misalign_q   <= misalign_d;
            if (accept) begin
                addr_q     <= addr_sum;
                be_q       <= be_calc;
                wdata_q    <= wdata_calc;
                is_store_q <= issue_is_store;
                funct3_q   <= issue_funct3;
                tag_q      <= issue_tag;
            end
            if (misalign_d) misalign_tag_q <= issue_tag;
            if (load_done)  load_q         <= load_data;
        end
    end

    // Outputs come straight from registers (or state decode), never from handshake inputs.
    assign o_busy           = (state_q != IDLE);
    assign bus.mem_req      = (state_q == MEM) || (state_q == DRAIN);
    assign bus.mem_we       = bus.mem_req && is_store_q;
    assign bus.mem_addr     = addr_q;
    assign bus.mem_be       = be_q;
    assign bus.mem_wdata    = wdata_q;
    assign bus.cdb_req      = (state_q == CDB);
    assign bus.cdb_tag_out  = tag_q;
    assign bus.cdb_data_out = load_q;
    assign o_store_done     = store_done_q;
    assign o_misalign       = misalign_q;
    assign o_misalign_tag   = misalign_tag_q;

endmodule

// File: tb/tb_ld_st_exec_unit.sv
// Directed bench for ld_st_exec_unit: inputs change and outputs are sampled on the falling edge.
module tb_ld_st_exec_unit;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        issue_valid = 1'b0;
    logic [31:0] issue_rs1_data = '0;
    logic [31:0] issue_rs2_data = '0;
    logic [31:0] issue_imm = '0;
    logic        issue_is_store = 1'b0;
    logic [2:0]  issue_funct3 = '0;
    logic [5:0]  issue_tag = '0;
    logic        o_busy;
    logic        o_store_done;
    logic        o_misalign;
    logic [5:0]  o_misalign_tag;

    int checks = 0;
    int failures = 0;

    ld_st_exec_unit_if #(.TAG_W(6)) bus ();

    ld_st_exec_unit #(.TAG_W(6)) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .flush          (flush),
        .issue_valid    (issue_valid),
        .issue_rs1_data (issue_rs1_data),
        .issue_rs2_data (issue_rs2_data),
        .issue_imm      (issue_imm),
        .issue_is_store (issue_is_store),
        .issue_funct3   (issue_funct3),
        .issue_tag      (issue_tag),
        .o_busy         (o_busy),
        .o_store_done   (o_store_done),
        .o_misalign     (o_misalign),
        .o_misalign_tag (o_misalign_tag),
        .bus            (bus)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [117:0] all_outs();
        return {o_busy, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata,
                bus.cdb_req, bus.cdb_tag_out, bus.cdb_data_out, o_store_done, o_misalign,
                o_misalign_tag};
    endfunction

    // Present one instruction for a single cycle; returns on the falling edge after acceptance.
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] rs1,
                         input logic [31:0] imm, input logic [31:0] rs2, input logic [5:0] tag);
        issue_valid    = 1'b1;
        issue_is_store = st;
        issue_funct3   = f3;
        issue_rs1_data = rs1;
        issue_imm      = imm;
        issue_rs2_data = rs2;
        issue_tag      = tag;
        @(negedge i_clk);
        issue_valid = 1'b0;
    endtask

    task automatic ack_cycle(input logic [31:0] rdata);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rdata;
        @(negedge i_clk);
        bus.mem_ack = 1'b0;
    endtask

    task automatic grant_cycle();
        bus.cdb_grant = 1'b1;
        @(negedge i_clk);
        bus.cdb_grant = 1'b0;
    endtask

    // Run a load with an immediate ack, wait (bounded) for the broadcast, grant it.
    task automatic do_load(input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] imm,
                           input logic [5:0] tag, input logic [31:0] rdata,
                           output logic [31:0] data, output logic [5:0] tag_out);
        int n = 0;
        issue(1'b0, f3, rs1, imm, 32'h0, tag);
        ack_cycle(rdata);
        while (bus.cdb_req !== 1'b1 && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        checks++;
        if (bus.cdb_req !== 1'b1) begin
            failures++;
            $display("FAIL load_cdb_timeout tag=%0d cdb_req=%b after %0d cycles, required 1", tag, bus.cdb_req, n);
        end
        data    = bus.cdb_data_out;
        tag_out = bus.cdb_tag_out;
        grant_cycle();
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        repeat (3) @(negedge i_clk);
        checks++;
        if (all_outs() !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h required=0", all_outs());
        end
        i_rst_n = 1'b1;
        @(negedge i_clk);
        checks++;
        if ({o_busy, bus.mem_req, bus.cdb_req} !== 3'b000) begin
            failures++;
            $display("FAIL idle_after_reset busy/req/cdb=%b required 000", {o_busy, bus.mem_req, bus.cdb_req});
        end
    endtask

    task automatic test_lw();
        issue(1'b0, 3'b010, 32'h0000_1000, 32'd4, 32'h0, 6'd5);
        checks++;
        if ({bus.mem_req, o_busy, bus.mem_we, bus.mem_be, bus.mem_addr} !== {3'b110, 4'b1111, 32'h1004}) begin
            failures++;
            $display("FAIL lw_request req/busy/we=%b be=%b addr=%h required 110 1111 00001004",
                     {bus.mem_req, o_busy, bus.mem_we}, bus.mem_be, bus.mem_addr);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge i_clk);
            checks++;
            if ({bus.mem_req, bus.mem_addr, bus.cdb_req} !== {1'b1, 32'h1004, 1'b0}) begin
                failures++;
                $display("FAIL lw_hold cycle %0d req=%b addr=%h cdb=%b required 1 00001004 0",
                         i, bus.mem_req, bus.mem_addr, bus.cdb_req);
            end
        end
        ack_cycle(32'hDEAD_BEEF);
        checks++;
        if ({bus.mem_req, bus.cdb_req, bus.cdb_tag_out, bus.cdb_data_out} !== {2'b01, 6'd5, 32'hDEAD_BEEF}) begin
            failures++;
            $display("FAIL lw_cdb req=%b cdb=%b tag=%0d data=%h required 0 1 5 deadbeef",
                     bus.mem_req, bus.cdb_req, bus.cdb_tag_out, bus.cdb_data_out);
        end
        grant_cycle();
        checks++;
        if ({bus.cdb_req, o_busy} !== 2'b00) begin
            failures++;
            $display("FAIL lw_after_grant cdb/busy=%b required 00", {bus.cdb_req, o_busy});
        end
    endtask

    task automatic test_load_extend();
        logic [31:0] d;
        logic [5:0]  t;
        do_load(3'b000, 32'h0000_2000, 32'd3, 6'd1, 32'h80FF_FF7F, d, t);
        checks++;
        if ({t, d} !== {6'd1, 32'hFFFF_FF80}) begin
            failures++;
            $display("FAIL lb_sext tag=%0d data=%h required 1 ffffff80", t, d);
        end
        do_load(3'b100, 32'h0000_2000, 32'd3, 6'd2, 32'h80FF_FF7F, d, t);
        checks++;
        if ({t, d} !== {6'd2, 32'h0000_0080}) begin
            failures++;
            $display("FAIL lbu_zext tag=%0d data=%h required 2 00000080", t, d);
        end
        do_load(3'b001, 32'h0000_2000, 32'd2, 6'd3, 32'h80FF_FF7F, d, t);
        checks++;
        if (d !== 32'hFFFF_80FF) begin
            failures++;
            $display("FAIL lh_sext data=%h required ffff80ff", d);
        end
        do_load(3'b101, 32'h0000_2000, 32'd0, 6'd4, 32'h80FF_FF7F, d, t);
        checks++;
        if (d !== 32'h0000_FF7F) begin
            failures++;
            $display("FAIL lhu_zext data=%h required 0000ff7f", d);
        end
    endtask

    task automatic test_store();
        issue(1'b1, 3'b001, 32'h0000_3000, 32'd2, 32'h0000_ABCD, 6'd7);
        checks++;
        if ({bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_wdata, bus.mem_addr} !==
            {2'b11, 4'b1100, 32'hABCD_ABCD, 32'h3002}) begin
            failures++;
            $display("FAIL sh_request req/we=%b be=%b wdata=%h addr=%h required 11 1100 abcdabcd 00003002",
                     {bus.mem_req, bus.mem_we}, bus.mem_be, bus.mem_wdata, bus.mem_addr);
        end
        @(negedge i_clk);
        ack_cycle(32'h0);
        checks++;
        if ({o_store_done, o_busy, bus.mem_req, bus.cdb_req} !== 4'b1000) begin
            failures++;
            $display("FAIL sh_done done/busy/req/cdb=%b required 1000",
                     {o_store_done, o_busy, bus.mem_req, bus.cdb_req});
        end
        @(negedge i_clk);
        checks++;
        if ({o_store_done, bus.cdb_req} !== 2'b00) begin
            failures++;
            $display("FAIL sh_done_pulse done/cdb=%b required 00", {o_store_done, bus.cdb_req});
        end
        // SB at 0x3001 reached through a negative offset
        issue(1'b1, 3'b000, 32'h0000_3005, 32'hFFFF_FFFC, 32'h1234_5678, 6'd8);
        checks++;
        if ({bus.mem_be, bus.mem_wdata, bus.mem_addr} !== {4'b0010, 32'h7878_7878, 32'h3001}) begin
            failures++;
            $display("FAIL sb_lanes be=%b wdata=%h addr=%h required 0010 78787878 00003001",
                     bus.mem_be, bus.mem_wdata, bus.mem_addr);
        end
        ack_cycle(32'h0);
        // SW whose address wraps past 2^32
        issue(1'b1, 3'b010, 32'hFFFF_FFFC, 32'd8, 32'hCAFE_F00D, 6'd9);
        checks++;
        if ({bus.mem_be, bus.mem_wdata, bus.mem_addr, bus.mem_we} !== {4'b1111, 32'hCAFE_F00D, 32'h4, 1'b1}) begin
            failures++;
            $display("FAIL sw_wrap be=%b wdata=%h addr=%h we=%b required 1111 cafef00d 00000004 1",
                     bus.mem_be, bus.mem_wdata, bus.mem_addr, bus.mem_we);
        end
        ack_cycle(32'h0);
        checks++;
        if (o_store_done !== 1'b1) begin
            failures++;
            $display("FAIL sw_done done=%b required 1", o_store_done);
        end
    endtask

    task automatic test_misalign();
        logic [31:0] d;
        logic [5:0]  t;
        issue(1'b0, 3'b010, 32'h0000_4000, 32'd2, 32'h0, 6'd9);
        checks++;
        if ({o_misalign, o_misalign_tag, bus.mem_req} !== {1'b1, 6'd9, 1'b0}) begin
            failures++;
            $display("FAIL lw_misalign pulse=%b tag=%0d req=%b required 1 9 0",
                     o_misalign, o_misalign_tag, bus.mem_req);
        end
        @(negedge i_clk);
        checks++;
        if ({o_misalign, o_busy, bus.mem_req, bus.cdb_req} !== 4'b0000) begin
            failures++;
            $display("FAIL lw_misalign_after pulse/busy/req/cdb=%b required 0000",
                     {o_misalign, o_busy, bus.mem_req, bus.cdb_req});
        end
        issue(1'b1, 3'b101, 32'h0000_4001, 32'd0, 32'h0, 6'd10);
        checks++;
        if ({o_misalign, o_misalign_tag, bus.mem_req} !== {1'b1, 6'd10, 1'b0}) begin
            failures++;
            $display("FAIL hu_misalign pulse=%b tag=%0d req=%b required 1 10 0",
                     o_misalign, o_misalign_tag, bus.mem_req);
        end
        // funct3 011 behaves as a word access
        issue(1'b0, 3'b011, 32'h0000_4002, 32'd0, 32'h0, 6'd12);
        checks++;
        if ({o_misalign, o_misalign_tag, bus.mem_req} !== {1'b1, 6'd12, 1'b0}) begin
            failures++;
            $display("FAIL illegal_f3_misalign pulse=%b tag=%0d req=%b required 1 12 0",
                     o_misalign, o_misalign_tag, bus.mem_req);
        end
        @(negedge i_clk);
        do_load(3'b000, 32'h0000_4001, 32'd0, 6'd11, 32'h0000_AB00, d, t);
        checks++;
        if ({t, d} !== {6'd11, 32'hFFFF_FFAB}) begin
            failures++;
            $display("FAIL lb_odd_addr tag=%0d data=%h required 11 ffffffab", t, d);
        end
    endtask

    task automatic test_flush();
        issue(1'b0, 3'b010, 32'h0000_5000, 32'd0, 32'h0, 6'd12);
        flush = 1'b1;
        @(negedge i_clk);
        flush = 1'b0;
        checks++;
        if ({bus.mem_req, o_busy, bus.mem_addr} !== {2'b11, 32'h5000}) begin
            failures++;
            $display("FAIL drain_hold req/busy=%b addr=%h required 11 00005000", {bus.mem_req, o_busy}, bus.mem_addr);
        end
        flush = 1'b1;
        @(negedge i_clk);
        flush = 1'b0;
        checks++;
        if (bus.mem_req !== 1'b1) begin
            failures++;
            $display("FAIL drain_second_flush req=%b required 1", bus.mem_req);
        end
        ack_cycle(32'h1111_1111);
        checks++;
        if ({bus.mem_req, bus.cdb_req, o_busy, o_store_done} !== 4'b0000) begin
            failures++;
            $display("FAIL drain_end req/cdb/busy/done=%b required 0000",
                     {bus.mem_req, bus.cdb_req, o_busy, o_store_done});
        end
        // store flushed in the same cycle as its ack
        issue(1'b1, 3'b010, 32'h0000_5100, 32'd0, 32'h5555_5555, 6'd13);
        flush = 1'b1;
        bus.mem_ack = 1'b1;
        @(negedge i_clk);
        flush = 1'b0;
        bus.mem_ack = 1'b0;
        checks++;
        if ({o_store_done, bus.mem_req, o_busy} !== 3'b000) begin
            failures++;
            $display("FAIL flush_with_ack done/req/busy=%b required 000", {o_store_done, bus.mem_req, o_busy});
        end
        // flush while the CDB request is up
        issue(1'b0, 3'b010, 32'h0000_5200, 32'd0, 32'h0, 6'd14);
        ack_cycle(32'h2222_2222);
        flush = 1'b1;
        @(negedge i_clk);
        flush = 1'b0;
        checks++;
        if ({bus.cdb_req, o_busy} !== 2'b00) begin
            failures++;
            $display("FAIL flush_cdb cdb/busy=%b required 00", {bus.cdb_req, o_busy});
        end
        // flush in IDLE blocks the issue
        flush = 1'b1;
        issue(1'b0, 3'b010, 32'h0000_5300, 32'd0, 32'h0, 6'd15);
        flush = 1'b0;
        checks++;
        if ({o_busy, bus.mem_req} !== 2'b00) begin
            failures++;
            $display("FAIL flush_idle busy/req=%b required 00", {o_busy, bus.mem_req});
        end
    endtask

    task automatic test_reset_mid();
        issue(1'b0, 3'b010, 32'h0000_6100, 32'd0, 32'h0, 6'd16);
        ack_cycle(32'h3333_3333);
        @(negedge i_clk);
        #2 i_rst_n = 1'b0;
        #1;
        checks++;
        if (all_outs() !== '0) begin
            failures++;
            $display("FAIL async_reset_mid_cdb got=%h required=0", all_outs());
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        issue(1'b0, 3'b010, 32'h0000_6000, 32'd0, 32'h0, 6'd20);
        checks++;
        if ({bus.mem_req, bus.mem_addr, o_store_done, o_misalign} !== {1'b1, 32'h6000, 2'b00}) begin
            failures++;
            $display("FAIL accept_after_reset req=%b addr=%h done/mis=%b required 1 00006000 00",
                     bus.mem_req, bus.mem_addr, {o_store_done, o_misalign});
        end
        ack_cycle(32'h0);
        grant_cycle();
    endtask

    task automatic test_back_to_back();
        issue(1'b1, 3'b010, 32'h0000_7000, 32'd0, 32'h0BAD_CAFE, 6'd21);
        ack_cycle(32'h0);
        issue(1'b0, 3'b010, 32'h0000_7008, 32'd0, 32'h0, 6'd22);
        checks++;
        if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {2'b10, 32'h7008}) begin
            failures++;
            $display("FAIL b2b_store_load req/we=%b addr=%h required 10 00007008", {bus.mem_req, bus.mem_we}, bus.mem_addr);
        end
        ack_cycle(32'h0123_4567);
        grant_cycle();
        issue(1'b0, 3'b010, 32'h0000_700C, 32'd0, 32'h0, 6'd23);
        checks++;
        if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h700C}) begin
            failures++;
            $display("FAIL b2b_after_grant req=%b addr=%h required 1 0000700c", bus.mem_req, bus.mem_addr);
        end
        ack_cycle(32'h0);
        checks++;
        if ({bus.cdb_req, bus.cdb_tag_out} !== {1'b1, 6'd23}) begin
            failures++;
            $display("FAIL b2b_cdb cdb=%b tag=%0d required 1 23", bus.cdb_req, bus.cdb_tag_out);
        end
        grant_cycle();
    endtask

    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        bus.cdb_grant = 1'b0;
        @(negedge i_clk);
        test_reset();
        test_lw();
        test_load_extend();
        test_store();
        test_misalign();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ld_st_exec_unit.md
# ld_st_exec_unit

The load/store execution unit sits directly downstream of the load/store issue queue. It accepts one operand-ready memory instruction at a time, computes the effective address, and runs a variable-latency request/acknowledge transaction with data memory. Loads are aligned and extended, then broadcast on the CDB through a request/grant arbiter. Stores complete silently with a done pulse.

## Interface
- TAG_W, 6: width of the physical/ROB tag carried to the CDB.

- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous squash of the in-flight instruction.
- issue_valid  in  1  issued entry present; both operands valid.
- issue_rs1_data  in  32  base register value.
- issue_rs2_data  in  32  store data (ignored for loads).
- issue_imm  in  32  sign-extended offset.
- issue_is_store  in  1  1 = store, 0 = load.
- issue_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU.
- issue_tag  in  TAG_W  destination tag.
- o_busy  out  1  unit occupied; upstream must not present issue_valid while high.
- mem_req, mem_we  out  1  memory request and write enable.
- mem_addr  out  32  byte address.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  read data, valid with mem_ack.
- mem_ack  in  1  transaction complete; sampled only while mem_req=1.
- cdb_req  out  1  request for the CDB.
- cdb_grant  in  1  grant, sampled only while cdb_req=1.
- cdb_tag_out  out  TAG_W  broadcast tag.
- cdb_data_out  out  32  broadcast data.
- o_store_done  out  1  one-cycle pulse when a store completes.
- o_misalign  out  1  one-cycle pulse when an access is misaligned.
- o_misalign_tag  out  TAG_W  tag of the misaligned access.

## Operation
- FSM states: IDLE, MEM, CDB, DRAIN. o_busy = (state != IDLE).
- IDLE:
  - Accept when issue_valid && !flush.
  - Register addr = rs1 + imm, modulo 2^32 with carry discarded.
  - Register tag, store flag, funct3 and store data.
- Alignment:
  - H/HU requires addr[0]=0.
  - W requires addr[1:0]=00.
  - B/BU are never misaligned.
- Misaligned access:
  - Pulse o_misalign with o_misalign_tag for one cycle.
  - Make no memory access and no CDB broadcast.
  - Return to IDLE.
- Otherwise go to MEM.
- MEM:
  - Hold mem_req=1 with constant mem_addr/mem_we/mem_be/mem_wdata until mem_ack.
- Store lane mapping:
  - SB: wdata={4{rs2[7:0]}}, be=4'b0001<<addr[1:0].
  - SH: wdata={2{rs2[15:0]}}, be = addr[1] ? 1100 : 0011.
  - SW: be=1111.
- Loads drive mem_we=0 and be=1111.
- On mem_ack:
  - Store: pulse o_store_done next cycle and go to IDLE.
  - Load: select the byte/half lane by addr[1:0]. Sign-extend for B/H, zero-extend for BU/HU. Register the result and go to CDB.
- CDB:
  - Hold cdb_req=1 with stable cdb_tag_out/cdb_data_out until cdb_grant, then go to IDLE.
- Illegal funct3 values (011, 110, 111) are treated as W.
- Flush:
  - In IDLE: the issue is not accepted.
  - In CDB: drop cdb_req and go to IDLE.
  - In MEM without mem_ack that cycle: go to DRAIN.
  - In MEM with mem_ack the same cycle: go to IDLE, discard the result, suppress o_store_done.
- DRAIN:
  - Keep mem_req=1 with the same attributes until mem_ack, then go to IDLE.
  - No CDB broadcast, no done pulse.
  - Further flushes have no extra effect.

## Timing
- Reset (async, immediate): state IDLE.
  - All outputs 0: o_busy, mem_req, mem_we, mem_addr, mem_be, mem_wdata, cdb_req, cdb_tag_out, cdb_data_out, o_store_done, o_misalign, o_misalign_tag.
- Reset mid-transaction abandons the operation and issues no pulses.
- Accept at cycle N → mem_req=1 and o_busy=1 from N+1.
- Misaligned access accepted at N → o_misalign pulses at N+1; o_busy low at N+2.
- mem_ack at M (load) → cdb_req=1 from M+1; mem_req=0 at M+1.
- cdb_grant at G → cdb_req=0 and o_busy=0 at G+1; next accept possible at G+1.
- Minimum load occupancy is 3 cycles: accept, MEM with immediate ack, CDB with immediate grant.
- Minimum store occupancy is 2 cycles; o_store_done pulses at M+1 and o_busy drops at M+1.
- All outputs are registered; none depends combinationally on mem_ack, cdb_grant or issue_*.

## Test plan
- LW, rs1=0x1000, imm=4, ack 3 cycles after req, mem_rdata=0xDEADBEEF, grant immediately:
  - Expect mem_addr=0x1004, be=1111.
  - Expect cdb_data_out=0xDEADBEEF with issue_tag, cdb_req for exactly 1 cycle.
- LB/LBU at addr 0x2003 with mem_rdata=0x80FF_FF7F: LB → cdb_data=0xFFFFFF80; LBU → 0x00000080.
- SH at addr 0x3002, rs2=0x0000ABCD:
  - Expect mem_we=1, be=1100, wdata=0xABCDABCD.
  - Expect o_store_done 1 cycle after ack and no cdb_req.
- LW at addr 0x4002: expect o_misalign pulse with tag, mem_req never asserted, o_busy low 2 cycles after accept.
- Flush while in MEM, ack 2 cycles later:
  - Expect mem_req held through the ack, then IDLE.
  - Expect no cdb_req and no o_store_done.
  - Repeat with flush while cdb_req is high: cdb_req drops the next cycle.
- Assert i_rst_n=0 mid-CDB with grant withheld: all outputs 0 immediately; new LW accepted on the first cycle after release.
